// File: rtl/prf_wb_arbiter.sv
// prf_wb_arbiter: round-robin arbiter sharing the PRF's two write ports
// among NREQ completing functional units. Grants up to two requests per
// cycle, registers the winners onto the write ports (which double as the
// wakeup broadcast), and keeps contention / duplicate-tag debug state.
module prf_wb_arbiter #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PREGS = 64,
  parameter int unsigned TAGW  = $clog2(PREGS),
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNTW  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*TAGW-1:0]   i_req_tag,
  input  logic [NREQ*XLEN-1:0]   i_req_data,
  output logic [NREQ-1:0]        o_req_ready,
  output logic                   o_wen0,
  output logic [TAGW-1:0]        o_wtag0,
  output logic [XLEN-1:0]        o_wdata0,
  output logic                   o_wen1,
  output logic [TAGW-1:0]        o_wtag1,
  output logic [XLEN-1:0]        o_wdata1,
  output logic [CNTW-1:0]        o_contention_cnt,
  output logic                   o_dup_tag_err
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NPAIR = NREQ * NREQ;

  logic [PTRW-1:0]  r_rr_ptr;
  logic             r_wen0;
  logic [TAGW-1:0]  r_wtag0;
  logic [XLEN-1:0]  r_wdata0;
  logic             r_wen1;
  logic [TAGW-1:0]  r_wtag1;
  logic [XLEN-1:0]  r_wdata1;
  logic [CNTW-1:0]  r_cnt;
  logic             r_dup;

  logic [TAGW-1:0]  w_tag_arr  [NREQ];
  logic [XLEN-1:0]  w_data_arr [NREQ];
  logic [NPAIR-1:0] w_dup_pair;
  logic             w_dup;

  logic             w_found0;
  logic             w_found1;
  logic [PTRW-1:0]  w_idx0;
  logic [PTRW-1:0]  w_idx1;
  logic [TAGW-1:0]  w_tag0;
  logic [PTRW:0]    w_sum;
  logic [PTRW-1:0]  w_idx;
  logic [NREQ-1:0]  w_grant;
  logic             w_slot0;
  logic             w_slot1;
  logic [PTRW-1:0]  w_last;
  logic [PTRW-1:0]  w_next_ptr;
  logic             w_contend;

  // Unpack the flattened request buses into per-requester arrays.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_tag_arr[g]  = i_req_tag[g*TAGW +: TAGW];
    assign w_data_arr[g] = i_req_data[g*XLEN +: XLEN];
  end

  // Pairwise tag collision detection among valid requesters.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_dup_i
    for (genvar gj = 0; gj < NREQ; gj++) begin : g_dup_j
      if (gj > gi) begin : g_pair
        assign w_dup_pair[gi*NREQ+gj] = i_req_valid[gi] && i_req_valid[gj] &&
                                        (w_tag_arr[gi] == w_tag_arr[gj]);
      end else begin : g_none
        assign w_dup_pair[gi*NREQ+gj] = 1'b0;
      end
    end
  end
  assign w_dup = |w_dup_pair;

  // Round-robin scan from r_rr_ptr: first valid wins slot 0, next valid
  // with a different tag wins slot 1.
  always_comb begin
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_idx0   = '0;
    w_idx1   = '0;
    w_tag0   = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PTRW+1)'(k);
      if (w_sum >= (PTRW+1)'(NREQ)) begin
        w_sum = w_sum - (PTRW+1)'(NREQ);
      end
      w_idx = w_sum[PTRW-1:0];
      if (i_req_valid[w_idx]) begin
        if (!w_found0) begin
          w_found0 = 1'b1;
          w_idx0   = w_idx;
          w_tag0   = w_tag_arr[w_idx];
        end else if (!w_found1 && (w_tag_arr[w_idx] != w_tag0)) begin
          w_found1 = 1'b1;
          w_idx1   = w_idx;
        end
      end
    end
  end

  // Grant vector; flush and reset void every grant this cycle.
  always_comb begin
    w_grant = '0;
    w_slot0 = w_found0 && !i_flush && !i_reset;
    w_slot1 = w_found1 && !i_flush && !i_reset;
    if (w_slot0) begin
      w_grant[w_idx0] = 1'b1;
    end
    if (w_slot1) begin
      w_grant[w_idx1] = 1'b1;
    end
  end
  assign o_req_ready = w_grant;

  // Pointer advances past the last granted requester.
  always_comb begin
    w_last     = w_found1 ? w_idx1 : w_idx0;
    w_next_ptr = '0;
    if (w_last != PTRW'(NREQ - 1)) begin
      w_next_ptr = w_last + PTRW'(1);
    end
  end

  assign w_contend = |(i_req_valid & ~w_grant);

  // Write-port registers, pointer, contention counter and sticky error.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr <= '0;
      r_wen0   <= 1'b0;
      r_wtag0  <= '0;
      r_wdata0 <= '0;
      r_wen1   <= 1'b0;
      r_wtag1  <= '0;
      r_wdata1 <= '0;
      r_cnt    <= '0;
      r_dup    <= 1'b0;
    end else begin
      r_wen0 <= w_slot0;
      r_wen1 <= w_slot1;
      if (w_slot0) begin
        r_wtag0  <= w_tag_arr[w_idx0];
        r_wdata0 <= w_data_arr[w_idx0];
        r_rr_ptr <= w_next_ptr;
      end
      if (w_slot1) begin
        r_wtag1  <= w_tag_arr[w_idx1];
        r_wdata1 <= w_data_arr[w_idx1];
      end
      if (!i_flush && w_contend && (r_cnt != {CNTW{1'b1}})) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
      if (w_dup) begin
        r_dup <= 1'b1;
      end
    end
  end

  assign o_wen0           = r_wen0;
  assign o_wtag0          = r_wtag0;
  assign o_wdata0         = r_wdata0;
  assign o_wen1           = r_wen1;
  assign o_wtag1          = r_wtag1;
  assign o_wdata1         = r_wdata1;
  assign o_contention_cnt = r_cnt;
  assign o_dup_tag_err    = r_dup;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed bench for prf_wb_arbiter: one task per scenario with inline checks.
module tb_prf_wb_arbiter;
  localparam int unsigned XLEN = 64;
  localparam int unsigned TAGW = 6;
  localparam int unsigned NREQ = 4;
  localparam int unsigned CNTW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wen0, wen1;
  logic [TAGW-1:0]      wtag0, wtag1;
  logic [XLEN-1:0]      wdata0, wdata1;
  logic [CNTW-1:0]      cnt;
  logic                 dup;

  // Second instance with a 3-bit counter for saturation checks.
  logic [NREQ-1:0]      s_ready;
  logic                 s_wen0, s_wen1, s_dup;
  logic [TAGW-1:0]      s_wtag0, s_wtag1;
  logic [XLEN-1:0]      s_wdata0, s_wdata1;
  logic [2:0]           s_cnt;

  int errors = 0;
  int checks = 0;

  prf_wb_arbiter #(.XLEN(XLEN), .PREGS(64), .NREQ(NREQ), .CNTW(CNTW)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_req_valid(req_valid), .i_req_tag(req_tag), .i_req_data(req_data),
    .o_req_ready(req_ready),
    .o_wen0(wen0), .o_wtag0(wtag0), .o_wdata0(wdata0),
    .o_wen1(wen1), .o_wtag1(wtag1), .o_wdata1(wdata1),
    .o_contention_cnt(cnt), .o_dup_tag_err(dup)
  );

  prf_wb_arbiter #(.XLEN(XLEN), .PREGS(64), .NREQ(NREQ), .CNTW(3)) u_small (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_req_valid(req_valid), .i_req_tag(req_tag), .i_req_data(req_data),
    .o_req_ready(s_ready),
    .o_wen0(s_wen0), .o_wtag0(s_wtag0), .o_wdata0(s_wdata0),
    .o_wen1(s_wen1), .o_wtag1(s_wtag1), .o_wdata1(s_wdata1),
    .o_contention_cnt(s_cnt), .o_dup_tag_err(s_dup)
  );

  task automatic set_req(input int i, input logic [TAGW-1:0] t, input logic [XLEN-1:0] d);
    req_tag[i*TAGW +: TAGW]  = t;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    set_req(0, 6'd5, 64'hAA);
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b%b want 00", wen0, wen1); end
    checks++; if (wtag0 !== '0 || wdata0 !== '0 || wtag1 !== '0 || wdata1 !== '0) begin errors++; $display("FAIL rst_wport: got %0d %0h %0d %0h want zeros", wtag0, wdata0, wtag1, wdata1); end
    checks++; if (cnt !== '0 || dup !== 1'b0) begin errors++; $display("FAIL rst_dbg: got cnt=%0d dup=%b want 0 0", cnt, dup); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 4'b0000 || wen0 !== 1'b0) begin errors++; $display("FAIL rst_hold: got ready=%b wen0=%b want 0000 0", req_ready, wen0); end
    #2;
    reset = 1'b0;
  endtask

  task automatic test_single();
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wtag0 !== 6'd5 || wdata0 !== 64'hAA || wen1 !== 1'b0) begin errors++; $display("FAIL single_port: got wen0=%b tag=%0d data=%0h wen1=%b want 1 5 aa 0", wen0, wtag0, wdata0, wen1); end
    // Pointer is now 1: requester 1 must win slot 0 over requester 0.
    req_valid = 4'b0011;
    set_req(1, 6'd8, 64'hBB);
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL ptr1_ready: got %b want 0011", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wtag0 !== 6'd8 || wdata0 !== 64'hBB || wen1 !== 1'b1 || wtag1 !== 6'd5 || wdata1 !== 64'hAA) begin errors++; $display("FAIL ptr1_ports: got %b/%0d/%0h %b/%0d/%0h want 1/8/bb 1/5/aa", wen0, wtag0, wdata0, wen1, wtag1, wdata1); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0 || wtag0 !== 6'd8 || wtag1 !== 6'd5) begin errors++; $display("FAIL idle_hold: got wen=%b%b tags %0d %0d want 00 8 5", wen0, wen1, wtag0, wtag1); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL single_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 64'h100 + 64'(i));
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rr_c1_ready: got %b want 0011", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wen1 !== 1'b1 || wtag0 !== 6'd1 || wtag1 !== 6'd2) begin errors++; $display("FAIL rr_c1_ports: got %b%b %0d %0d want 11 1 2", wen0, wen1, wtag0, wtag1); end
    checks++; if (cnt !== 32'd1 || req_ready !== 4'b1100) begin errors++; $display("FAIL rr_c2_state: got cnt=%0d ready=%b want 1 1100", cnt, req_ready); end
    @(posedge clk); #1;
    checks++; if (wtag0 !== 6'd3 || wtag1 !== 6'd4 || wdata1 !== 64'h103 || cnt !== 32'd2 || req_ready !== 4'b0011) begin errors++; $display("FAIL rr_c2_ports: got %0d %0d %0h cnt=%0d ready=%b want 3 4 103 2 0011", wtag0, wtag1, wdata1, cnt, req_ready); end
    @(posedge clk); #1;
    checks++; if (wtag0 !== 6'd1 || wtag1 !== 6'd2 || wdata0 !== 64'h100 || cnt !== 32'd3) begin errors++; $display("FAIL rr_c3_ports: got %0d %0d %0h cnt=%0d want 1 2 100 3", wtag0, wtag1, wdata0, cnt); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b0 || cnt !== 32'd3) begin errors++; $display("FAIL rr_idle: got wen0=%b cnt=%0d want 0 3", wen0, cnt); end
  endtask

  task automatic test_dup_tag();
    pulse_reset();
    req_valid = 4'b0111;
    set_req(0, 6'd7, 64'h70);
    set_req(1, 6'd7, 64'h71);
    set_req(2, 6'd9, 64'h90);
    #1;
    checks++; if (req_ready !== 4'b0101) begin errors++; $display("FAIL dup_ready: got %b want 0101", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wtag0 !== 6'd7 || wdata0 !== 64'h70 || wen1 !== 1'b1 || wtag1 !== 6'd9 || wdata1 !== 64'h90) begin errors++; $display("FAIL dup_ports: got %b/%0d/%0h %b/%0d/%0h want 1/7/70 1/9/90", wen0, wtag0, wdata0, wen1, wtag1, wdata1); end
    checks++; if (dup !== 1'b1 || cnt !== 32'd1) begin errors++; $display("FAIL dup_flag: got dup=%b cnt=%0d want 1 1", dup, cnt); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    checks++; if (dup !== 1'b1 || wen0 !== 1'b0) begin errors++; $display("FAIL dup_sticky: got dup=%b wen0=%b want 1 0", dup, wen0); end
  endtask

  task automatic test_flush();
    pulse_reset();
    req_valid = 4'b0001;
    set_req(0, 6'd3, 64'h33);
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wtag0 !== 6'd3 || dup !== 1'b0) begin errors++; $display("FAIL fl_pre: got wen0=%b tag=%0d dup=%b want 1 3 0", wen0, wtag0, dup); end
    req_valid = 4'b0011;
    set_req(0, 6'd1, 64'h11);
    set_req(1, 6'd2, 64'h22);
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL fl_ready: got %b want 0000", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0 || cnt !== 32'd0 || wtag0 !== 6'd3) begin errors++; $display("FAIL fl_ports: got wen=%b%b cnt=%0d tag0=%0d want 00 0 3", wen0, wen1, cnt, wtag0); end
    flush = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL fl_after_ready: got %b want 0011", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wtag0 !== 6'd2 || wdata0 !== 64'h22 || wen1 !== 1'b1 || wtag1 !== 6'd1 || cnt !== 32'd0) begin errors++; $display("FAIL fl_after_ports: got %b/%0d/%0h %b/%0d cnt=%0d want 1/2/22 1/1 0", wen0, wtag0, wdata0, wen1, wtag1, cnt); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 64'h100 + 64'(i));
    #1;
    checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL mid_ready: got %b want 0110", req_ready); end
    @(posedge clk); #1;
    checks++; if (wtag0 !== 6'd2 || wtag1 !== 6'd3 || cnt !== 32'd1) begin errors++; $display("FAIL mid_pre: got %0d %0d cnt=%0d want 2 3 1", wtag0, wtag1, cnt); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0 || wtag0 !== '0 || cnt !== '0 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_async: got wen=%b%b tag0=%0d cnt=%0d ready=%b want 00 0 0 0000", wen0, wen1, wtag0, cnt, req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0) begin errors++; $display("FAIL mid_hold: got wen=%b%b want 00", wen0, wen1); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL mid_release_ready: got %b want 0011", req_ready); end
    @(posedge clk); #1;
    checks++; if (wen0 !== 1'b1 || wen1 !== 1'b1 || wtag0 !== 6'd1 || wtag1 !== 6'd2 || cnt !== 32'd1) begin errors++; $display("FAIL mid_release_ports: got %b%b %0d %0d cnt=%0d want 11 1 2 1", wen0, wen1, wtag0, wtag1, cnt); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    req_valid = 4'b1111;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (s_cnt !== 3'd6 || cnt !== 32'd6) begin errors++; $display("FAIL sat_6: got small=%0d main=%0d want 6 6", s_cnt, cnt); end
    @(posedge clk); #1;
    checks++; if (s_cnt !== 3'd7) begin errors++; $display("FAIL sat_7: got %0d want 7", s_cnt); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_cnt !== 3'd7 || cnt !== 32'd9) begin errors++; $display("FAIL sat_hold: got small=%0d main=%0d want 7 9", s_cnt, cnt); end
    req_valid = 4'b0000;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_dup_tag();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/prf_wb_arbiter.md
Name: prf_wb_arbiter

Overview:
Shares the physical register file's two write ports among NREQ completing functional units (ALU0, ALU1, LSU, BRU by default).
- Grants up to two writeback requests per cycle in round-robin order.
- Registers the winners onto the PRF write-port signals (wen0/wtag0/wdata0, wen1/wtag1/wdata1).
- Keeps a saturating contention counter and a sticky duplicate-tag error flag for debug.
- Sits between execution-unit result buses and the PRF; its registered outputs also serve as the wakeup broadcast.

Parameters:
- XLEN, 64, data width of a register value.
- PREGS, 64, number of physical registers.
- TAGW, $clog2(PREGS), width of a physical register tag.
- NREQ, 4, number of requesting units; legal range 2..8.
- CNTW, 32, width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; drops this cycle's grants.
- req_valid  in  NREQ  requester i has a result to write.
- req_tag  in  NREQ*TAGW  destination physical tag, slice i.
- req_data  in  NREQ*XLEN  result value, slice i.
- req_ready  out  NREQ  combinational grant; a transfer occurs when req_valid[i] && req_ready[i].
- wen0  out  1  PRF write-port-0 enable (registered).
- wtag0  out  TAGW  PRF write-port-0 tag.
- wdata0  out  XLEN  PRF write-port-0 data.
- wen1  out  1  PRF write-port-1 enable (registered).
- wtag1  out  TAGW  PRF write-port-1 tag.
- wdata1  out  XLEN  PRF write-port-1 data.
- contention_cnt  out  CNTW  cycles in which at least one valid request was not granted.
- dup_tag_err  out  1  sticky; two valid requests carried the same tag in one cycle.

Behaviour:
Reset (asynchronous, active-high):
- wen0 = wen1 = 0; wtag0/1, wdata0/1 = 0.
- rr_ptr = 0; contention_cnt = 0; dup_tag_err = 0.
- req_ready = 0 while reset is asserted.
- Reset asserted mid-transfer: any grant in that cycle is void; requesters must keep holding.

Handshake:
- A requester asserts req_valid with a stable tag and data until it sees req_ready high in the same cycle.
- req_valid must not depend on req_ready.

Arbitration (combinational):
- Scan indices rr_ptr, rr_ptr+1, … mod NREQ.
- First valid index found -> slot 0 (port 0). Second valid index -> slot 1 (port 1).
- At most two grants per cycle.

Duplicate tag:
- If the slot-1 candidate has the same tag as the slot-0 winner, it is not granted this cycle.
- The scan continues to the next valid index with a different tag.
- dup_tag_err is set and stays set until reset.

Flush:
- When flush = 1, req_ready = 0 for all requesters.
- wen0 = wen1 = 0 on the next edge.
- rr_ptr and contention_cnt are unchanged.

Pointer update:
- If any grant occurs, rr_ptr <= (index of last granted requester + 1) mod NREQ.
- Otherwise rr_ptr holds.
- Guarantee: any continuously-valid requester is granted within ceil(NREQ/2) cycles.

Latency:
- A request granted in cycle N appears on wen/wtag/wdata in cycle N+1, for exactly one cycle.
- The slot-0 grant always drives port 0; the slot-1 grant always drives port 1.
- wen1 = 1 with wen0 = 0 never occurs.
- Ports without a grant get wen = 0; their wtag and wdata hold their previous values.
- The PRF gives port 0 priority on equal tags; the duplicate-tag rule above ensures that case never occurs.

Counter:
- contention_cnt increments when popcount(req_valid) > popcount(grants) and flush = 0 and reset = 0.
- It saturates at all-ones and does not wrap.

Test Plan:
1. Reset, then req_valid = 0001, tag 5, data 0xAA -> req_ready = 0001 same cycle; next cycle wen0 = 1, wtag0 = 5, wdata0 = 0xAA, wen1 = 0; rr_ptr = 1.
2. From rr_ptr = 0, req_valid = 1111 held with distinct tags 1..4 -> grants {0,1}, then {2,3}, then {0,1}; port pairs (1,2), (3,4), (1,2); contention_cnt +1 per cycle.
3. Duplicate tag: rr_ptr = 0, requesters 0 and 1 both tag 7, requester 2 tag 9 -> grants {0,2}; wtag0 = 7, wtag1 = 9; dup_tag_err = 1 and stays 1 after the requests clear.
4. Flush with req_valid = 0011 -> req_ready = 0000; next cycle wen0 = wen1 = 0; rr_ptr unchanged; after flush drops, grants {0,1} proceed.
5. Assert reset asynchronously mid-cycle while 2 grants are pending -> wen0/1 = 0 immediately, counters cleared; after release, the held requests are granted from rr_ptr = 0.
6. Saturation: preload contention_cnt to 0xFFFFFFFE (via CNTW = 32 force or long run), 3 cycles of contention -> 0xFFFFFFFF, stays there.
